// File: rtl/id_inst_queue_pkg.sv
// ============================================================================
// Module   : id_inst_queue_pkg
// Purpose  : Shared types and constants for the IF->ID instruction queue.
//            - id_q_state_t : queue control state (NORMAL / DS_WAIT)
//            - ID_Q_ENTRY_WD: default packed {pc, inst} entry width
// Config   : none (ID_QUEUE_BYPASS_EN is consumed by id_inst_queue)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package id_inst_queue_pkg;

    // NORMAL : ordinary queue operation
    // DS_WAIT: a taken branch has left the queue, its delay slot not yet fetched
    typedef enum logic [0:0] {
        ID_Q_NORMAL  = 1'b0,
        ID_Q_DS_WAIT = 1'b1
    } id_q_state_t;

    // Default width of one packed {pc, inst} entry (PC_W + INST_W = 32 + 32)
    localparam int ID_Q_ENTRY_WD = 64;

endpackage

`default_nettype wire

// File: rtl/id_queue_ram.sv
// ============================================================================
// Module   : id_queue_ram
// Purpose  : DEPTH x WIDTH register array backing the instruction queue.
//            One synchronous write port, one asynchronous read port.
//            Storage is deliberately not reset; the control logic never
//            presents an unwritten slot as valid.
// Ports    : clk        - clock
//            i_wr_en    - write strobe
//            i_wr_addr  - write slot
//            i_wr_data  - packed entry to store
//            i_rd_addr  - read slot
//            o_rd_data  - packed entry at i_rd_addr (combinational)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_queue_ram
    import id_inst_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ID_Q_ENTRY_WD
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/id_inst_queue.sv
// ============================================================================
// Module   : id_inst_queue
// Purpose  : DEPTH-entry circular queue of {pc, inst} between IF and ID with
//            valid/ready on both sides. Handles MIPS branch-delay-slot
//            retention on a taken branch and full discard on exception.
// Ports    : clk, rst (async, active-low)
//            in_valid/in_ready/in_pc/in_inst     - IF side
//            out_valid/out_ready/out_pc/out_inst - ID side (data 0 when idle)
//            br_taken  - head being popped is a taken branch/jump
//            exc_flush - discard all contents (highest priority)
//            level     - registered occupancy
// Config   : `define ID_QUEUE_BYPASS_EN for 0-cycle pass-through when the
//            queue is empty in NORMAL state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_inst_queue
    import id_inst_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    input  logic                     br_taken,
    input  logic                     exc_flush,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_ENTRY_W = PC_W + INST_W;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_TWO  = c_CNT_W'(2);

    id_q_state_t          r_state;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;

    logic                 w_q_valid;
    logic                 w_bypass;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_byp_pop;
    logic                 w_br;
    logic                 w_keep;
    logic                 w_wr_en;
    logic [c_ENTRY_W-1:0] w_rd_data;

    // ------------------------------------------------------------------
    // Handshake and qualification
    // ------------------------------------------------------------------
    always_comb begin
        w_q_valid = (r_state == ID_Q_NORMAL) && (r_count != '0);
`ifdef ID_QUEUE_BYPASS_EN
        w_bypass  = (r_count == '0) && (r_state == ID_Q_NORMAL) && in_valid && !exc_flush;
`else
        w_bypass  = 1'b0;
`endif
        // A full queue refuses the push even if the head leaves this cycle.
        in_ready  = (r_count != c_FULL);
        out_valid = w_q_valid || w_bypass;

        w_push    = in_valid && in_ready;
        w_pop     = w_q_valid && out_ready;
        w_byp_pop = w_bypass && out_ready;

        // br_taken only means something when a NORMAL-state pop happens.
        w_br      = br_taken && (r_state == ID_Q_NORMAL) && (w_pop || w_byp_pop);
        // Entries left behind the branch: the next one is the delay slot.
        w_keep    = w_br && w_pop && (r_count >= c_TWO);

        // A bypassed entry is consumed without being stored; when the delay
        // slot is already queued, a concurrent fetch is off-path.
        w_wr_en   = w_push && !exc_flush && !w_keep && !w_byp_pop;

        out_pc    = '0;
        out_inst  = '0;
        if (w_q_valid) begin
            {out_pc, out_inst} = w_rd_data;
        end else if (w_bypass) begin
            out_pc   = in_pc;
            out_inst = in_inst;
        end

        level     = r_count;
    end

    // ------------------------------------------------------------------
    // Pointer / count / state update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ID_Q_NORMAL;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (exc_flush) begin
            r_state  <= ID_Q_NORMAL;
            r_count  <= '0;
            r_wr_ptr <= r_rd_ptr;
        end else if (r_state == ID_Q_DS_WAIT) begin
            // Queue is empty here; the first fetch is the delay slot.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                r_count  <= c_ONE;
                r_state  <= ID_Q_NORMAL;
            end
        end else if (w_byp_pop) begin
            if (br_taken) begin
                r_state <= ID_Q_DS_WAIT;
            end
        end else if (w_br) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            if (w_keep) begin
                // Truncate the queue right after the delay slot.
                r_wr_ptr <= r_rd_ptr + c_PTR_W'(2);
                r_count  <= c_ONE;
            end else if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                r_count  <= c_ONE;
            end else begin
                r_count  <= '0;
                r_state  <= ID_Q_DS_WAIT;
            end
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    id_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data ({in_pc, in_inst}),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

endmodule

`default_nettype wire
